dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/soc_bus_pkg.sv | 17 +
 rtl/dmem_arb_select.sv | 75 +++++++
 rtl/dmem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared bus types: arbiter FSM states and grant encodings.
// Imported by dmem_arbiter and dmem_arb_select.
package soc_bus_pkg;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_RESP = 1'b1
    } arb_state_e;

    typedef logic [1:0] gnt_t;

    localparam gnt_t GNT_NONE = 2'd0;
    localparam gnt_t GNT_CPU  = 2'd1;
    localparam gnt_t GNT_CONV = 2'd2;
    localparam gnt_t GNT_DP   = 2'd3;

endpackage

// File: rtl/dmem_arb_select.sv
// Winner selection: CPU priority, conv/dp round-robin, optional starvation guard.
// Ports: clk_i, reset_i, *_req_i, take_i (FSM accepted winner), winner_o.
// Macro DMEM_ARBITER_STARVE_GUARD_EN enables the starvation counter.
module dmem_arb_select
    import soc_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic cpu_req_i,
    input  logic conv_req_i,
    input  logic dp_req_i,
    input  logic take_i,
    output gnt_t winner_o
);

    logic dsp_pend;
    logic prefer_dp;
    logic force_dsp;
    gnt_t dsp_pick;

    assign dsp_pend = conv_req_i | dp_req_i;

    always_comb begin
        dsp_pick = GNT_DP;
        if (conv_req_i && dp_req_i) begin
            dsp_pick = prefer_dp ? GNT_DP : GNT_CONV;
        end else if (conv_req_i) begin
            dsp_pick = GNT_CONV;
        end
    end

`ifdef DMEM_ARBITER_STARVE_GUARD_EN
    logic [3:0] starve_q;

    assign force_dsp = dsp_pend && (starve_q == 4'(STARVE_LIMIT));

    // Counts CPU wins that overtook a waiting DSP.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            starve_q <= '0;
        end else if (!dsp_pend) begin
            starve_q <= '0;
        end else if (take_i) begin
            if (winner_o == GNT_CPU) begin
                starve_q <= starve_q + 4'd1;
            end else begin
                starve_q <= '0;
            end
        end
    end
`else
    assign force_dsp = 1'b0;
`endif

    always_comb begin
        winner_o = GNT_NONE;
        if (cpu_req_i && !force_dsp) begin
            winner_o = GNT_CPU;
        end else if (dsp_pend) begin
            winner_o = dsp_pick;
        end
    end

    // Pointer moves only on DSP wins; reset favours conv.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            prefer_dp <= 1'b0;
        end else if (take_i && winner_o[1]) begin
            prefer_dp <= (winner_o == GNT_CONV);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Three-requester (cpu, conv, dp) arbiter onto one sync-read data memory.
// Ports: clk_i, reset_i, per-requester req/we/addr/wdata in, ack/err/rdata out,
// dm_* memory port, grant_o, busy_o. Macro: DMEM_ARBITER_STARVE_GUARD_EN.
module dmem_arbiter
    import soc_bus_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE_ADDR = '0,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      cpu_req_i,
    input  logic                      cpu_we_i,
    input  logic [ADDR_WIDTH-1:0]     cpu_addr_i,
    input  logic [DATA_WIDTH-1:0]     cpu_wdata_i,
    input  logic                      conv_req_i,
    input  logic                      conv_we_i,
    input  logic [ADDR_WIDTH-1:0]     conv_addr_i,
    input  logic [DATA_WIDTH-1:0]     conv_wdata_i,
    input  logic                      dp_req_i,
    input  logic                      dp_we_i,
    input  logic [ADDR_WIDTH-1:0]     dp_addr_i,
    input  logic [DATA_WIDTH-1:0]     dp_wdata_i,
    output logic                      cpu_ack_o,
    output logic                      cpu_err_o,
    output logic [DATA_WIDTH-1:0]     cpu_rdata_o,
    output logic                      conv_ack_o,
    output logic                      conv_err_o,
    output logic [DATA_WIDTH-1:0]     conv_rdata_o,
    output logic                      dp_ack_o,
    output logic                      dp_err_o,
    output logic [DATA_WIDTH-1:0]     dp_rdata_o,
    output logic [MEM_ADDR_WIDTH-1:0] dm_addr_o,
    output logic [DATA_WIDTH-1:0]     dm_wdata_o,
    output logic                      dm_we_o,
    output logic                      dm_re_o,
    input  logic [DATA_WIDTH-1:0]     dm_rdata_i,
    output logic [1:0]                grant_o,
    output logic                      busy_o
);

    // One extra bit so base + span cannot wrap.
    localparam logic [ADDR_WIDTH:0] BASE_EXT = {1'b0, MEM_BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] SPAN =
        (ADDR_WIDTH+1)'(1) << (MEM_ADDR_WIDTH + 2);
    localparam logic [ADDR_WIDTH:0] TOP_EXT =
        BASE_EXT + SPAN - (ADDR_WIDTH+1)'(1);

    arb_state_e state_q, state_d;
    gnt_t       grant_q, grant_d;
    logic       err_q, err_d;
    logic       we_q, we_d;
    gnt_t       winner;
    logic       take;

    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] rd;

    dmem_arb_select #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_sel (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .cpu_req_i (cpu_req_i),
        .conv_req_i(conv_req_i),
        .dp_req_i  (dp_req_i),
        .take_i    (take),
        .winner_o  (winner)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        unique case (winner)
            GNT_CPU: begin
                sel_we    = cpu_we_i;
                sel_addr  = cpu_addr_i;
                sel_wdata = cpu_wdata_i;
            end
            GNT_CONV: begin
                sel_we    = conv_we_i;
                sel_addr  = conv_addr_i;
                sel_wdata = conv_wdata_i;
            end
            GNT_DP: begin
                sel_we    = dp_we_i;
                sel_addr  = dp_addr_i;
                sel_wdata = dp_wdata_i;
            end
            default: ;
        endcase
    end

    assign in_range = ({1'b0, sel_addr} >= BASE_EXT) &&
                      ({1'b0, sel_addr} <= TOP_EXT);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_ARB;
            grant_q <= GNT_NONE;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            we_q    <= we_d;
        end
    end

    // Memory strobes are combinational in ARB so the sync read lands in RESP.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        err_d      = err_q;
        we_d       = we_q;
        take       = 1'b0;
        dm_addr_o  = '0;
        dm_wdata_o = '0;
        dm_we_o    = 1'b0;
        dm_re_o    = 1'b0;
        unique case (state_q)
            ST_ARB: begin
                if (!reset_i && winner != GNT_NONE) begin
                    take    = 1'b1;
                    state_d = ST_RESP;
                    grant_d = winner;
                    err_d   = !in_range;
                    we_d    = sel_we;
                    if (in_range) begin
                        dm_addr_o  = sel_addr[MEM_ADDR_WIDTH+1:2];
                        dm_wdata_o = sel_wdata;
                        dm_we_o    = sel_we;
                        dm_re_o    = !sel_we;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_ARB;
                grant_d = GNT_NONE;
            end
            default: state_d = ST_ARB;
        endcase
    end

    assign rd = (we_q || err_q) ? '0 : dm_rdata_i;

    always_comb begin
        cpu_ack_o    = 1'b0;
        cpu_err_o    = 1'b0;
        cpu_rdata_o  = '0;
        conv_ack_o   = 1'b0;
        conv_err_o   = 1'b0;
        conv_rdata_o = '0;
        dp_ack_o     = 1'b0;
        dp_err_o     = 1'b0;
        dp_rdata_o   = '0;
        if (state_q == ST_RESP) begin
            unique case (grant_q)
                GNT_CPU: begin
                    cpu_ack_o   = 1'b1;
                    cpu_err_o   = err_q;
                    cpu_rdata_o = rd;
                end
                GNT_CONV: begin
                    conv_ack_o   = 1'b1;
                    conv_err_o   = err_q;
                    conv_rdata_o = rd;
                end
                GNT_DP: begin
                    dp_ack_o   = 1'b1;
                    dp_err_o   = err_q;
                    dp_rdata_o = rd;
                end
                default: ;
            endcase
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == ST_RESP);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed traffic, cycle model, memory.
// Honours DMEM_ARBITER_STARVE_GUARD_EN for the starvation expectations.
module tb_dmem_arbiter;

    localparam int LIMIT = 4;
`ifdef DMEM_ARBITER_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cpu_req = 0, cpu_we = 0, conv_req = 0, conv_we = 0;
    logic        dp_req = 0, dp_we = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, conv_addr = 0, conv_wdata = 0;
    logic [31:0] dp_addr = 0, dp_wdata = 0;
    logic        cpu_ack, cpu_err, conv_ack, conv_err, dp_ack, dp_err;
    logic [31:0] cpu_rdata, conv_rdata, dp_rdata;
    logic [7:0]  dm_addr;
    logic [31:0] dm_wdata, dm_rdata;
    logic        dm_we, dm_re;
    logic [1:0]  grant;
    logic        busy;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .reset_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .conv_req_i(conv_req), .conv_we_i(conv_we),
        .conv_addr_i(conv_addr), .conv_wdata_i(conv_wdata),
        .dp_req_i(dp_req), .dp_we_i(dp_we),
        .dp_addr_i(dp_addr), .dp_wdata_i(dp_wdata),
        .cpu_ack_o(cpu_ack), .cpu_err_o(cpu_err), .cpu_rdata_o(cpu_rdata),
        .conv_ack_o(conv_ack), .conv_err_o(conv_err), .conv_rdata_o(conv_rdata),
        .dp_ack_o(dp_ack), .dp_err_o(dp_err), .dp_rdata_o(dp_rdata),
        .dm_addr_o(dm_addr), .dm_wdata_o(dm_wdata),
        .dm_we_o(dm_we), .dm_re_o(dm_re), .dm_rdata_i(dm_rdata),
        .grant_o(grant), .busy_o(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Data memory with synchronous read, plus the model's own shadow copy.
    logic [31:0] mem [256];
    logic [31:0] shadow [256];
    logic [31:0] mem_q = '0;
    assign dm_rdata = mem_q;
    always @(posedge clk) begin
        if (dm_we) mem[dm_addr] <= dm_wdata;
        if (dm_re) mem_q <= mem[dm_addr];
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t q_cpu[$], q_conv[$], q_dp[$];
    logic [2:0] ack_seen = '0;
    always @(negedge clk) ack_seen <= {dp_ack, conv_ack, cpu_ack};

    // Requesters: hold until an ack at a clock edge outside reset.
    initial begin
        txn_t t;
        logic r;
        forever begin
            @(posedge clk);
            r = rst;
            #1;
            if (cpu_req && ack_seen[0] && !r) cpu_req = 0;
            if (conv_req && ack_seen[1] && !r) conv_req = 0;
            if (dp_req && ack_seen[2] && !r) dp_req = 0;
            if (!cpu_req && q_cpu.size() > 0) begin
                t = q_cpu.pop_front();
                cpu_req = 1; cpu_we = t.we;
                cpu_addr = t.addr; cpu_wdata = t.wdata;
            end
            if (!conv_req && q_conv.size() > 0) begin
                t = q_conv.pop_front();
                conv_req = 1; conv_we = t.we;
                conv_addr = t.addr; conv_wdata = t.wdata;
            end
            if (!dp_req && q_dp.size() > 0) begin
                t = q_dp.pop_front();
                dp_req = 1; dp_we = t.we;
                dp_addr = t.addr; dp_wdata = t.wdata;
            end
        end
    end

    // Behavioural model: who is being served, and the fairness bookkeeping.
    int          m_busy = 0;
    int          m_own = 0;
    bit          m_err = 0;
    logic [31:0] m_rd = 0;
    int          m_last = 3;
    int          m_cnt = 0;

    function automatic int pick();
        bit dsp = conv_req || dp_req;
        bit starved = GUARD && dsp && (m_cnt == LIMIT);
        if (cpu_req && !starved) return 1;
        if (conv_req && dp_req) return (m_last == 2) ? 3 : 2;
        if (conv_req) return 2;
        if (dp_req) return 3;
        return 0;
    endfunction

    function automatic txn_t fields(input int w);
        txn_t t;
        t.we = 0; t.addr = 0; t.wdata = 0;
        if (w == 1) begin t.we = cpu_we; t.addr = cpu_addr; t.wdata = cpu_wdata; end
        if (w == 2) begin t.we = conv_we; t.addr = conv_addr; t.wdata = conv_wdata; end
        if (w == 3) begin t.we = dp_we; t.addr = dp_addr; t.wdata = dp_wdata; end
        return t;
    endfunction

    function automatic bit ok_addr(input logic [31:0] a);
        return a < 32'h400;
    endfunction

    initial begin
        int w;
        txn_t t;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_busy = 0; m_last = 3; m_cnt = 0;
            end else if (m_busy != 0) begin
                m_busy = 0;
            end else begin
                w = pick();
                if (w != 0) begin
                    t = fields(w);
                    m_busy = 1;
                    m_own = w;
                    m_err = !ok_addr(t.addr);
                    m_rd = (t.we || m_err) ? 32'h0 : shadow[t.addr[9:2]];
                    if (t.we && !m_err) shadow[t.addr[9:2]] = t.wdata;
                    if (w >= 2) begin
                        m_last = w; m_cnt = 0;
                    end else if (conv_req || dp_req) begin
                        m_cnt++;
                    end
                end
            end
            if (!rst && !conv_req && !dp_req) m_cnt = 0;
        end
    end

    // Cycle compare and monitors.
    int cpu_acks = 0;
    int gl[$];
    initial begin
        logic [2:0]  e_ack, e_err;
        logic [31:0] e_rd [3];
        logic [7:0]  e_da;
        logic [31:0] e_dw;
        logic        e_we, e_re, e_busy;
        logic [1:0]  e_gnt;
        int w;
        txn_t t;
        forever begin
            @(negedge clk);
            if (cpu_ack) cpu_acks++;
            if (busy) gl.push_back(int'(grant));
            e_ack = 0; e_err = 0; e_da = 0; e_dw = 0; e_we = 0; e_re = 0;
            e_busy = 0; e_gnt = 0;
            for (int i = 0; i < 3; i++) e_rd[i] = 0;
            if (!rst) begin
                if (m_busy != 0) begin
                    e_busy = 1;
                    e_gnt = 2'(m_own);
                    e_ack[m_own-1] = 1;
                    e_err[m_own-1] = m_err;
                    e_rd[m_own-1] = m_rd;
                end else begin
                    w = pick();
                    t = fields(w);
                    if (w != 0 && ok_addr(t.addr)) begin
                        e_da = t.addr[9:2]; e_dw = t.wdata;
                        e_we = t.we; e_re = !t.we;
                    end
                end
            end
            chk("grant", grant, e_gnt);
            chk("busy", busy, e_busy);
            chk("dm_addr", dm_addr, e_da);
            chk("dm_wdata", dm_wdata, e_dw);
            chk("dm_we", dm_we, e_we);
            chk("dm_re", dm_re, e_re);
            chk("ack", {dp_ack, conv_ack, cpu_ack}, e_ack);
            chk("err", {dp_err, conv_err, cpu_err}, e_err);
            chk("cpu_rdata", cpu_rdata, e_rd[0]);
            chk("conv_rdata", conv_rdata, e_rd[1]);
            chk("dp_rdata", dp_rdata, e_rd[2]);
        end
    end

    task automatic do_reset();
        @(posedge clk); #2 rst = 1;
        @(posedge clk);
        @(posedge clk); #3 rst = 0;
    endtask

    task automatic wait_idle(input int maxc);
        int k = 0;
        while ((q_cpu.size() + q_conv.size() + q_dp.size() > 0 ||
                cpu_req || conv_req || dp_req || busy) && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", k < maxc, 1);
    endtask

    function automatic txn_t mk(input logic we, input logic [31:0] a,
                                input logic [31:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        return t;
    endfunction

    initial begin
        int exp_g [6];
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'hA500_0000 + 32'(i * 3);
            shadow[i] = mem[i];
        end
        mem[4] = 32'hDEAD_BEEF;
        shadow[4] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #3 rst = 0;

        @(negedge clk);
        chk("reset_grant", grant, 0);
        chk("reset_busy", busy, 0);

        // CPU read of word 4
        @(posedge clk);
        q_cpu.push_back(mk(0, 32'h10, 0));
        @(negedge clk);
        chk("rd_dm_re", dm_re, 1);
        chk("rd_dm_addr", dm_addr, 4);
        @(negedge clk);
        chk("rd_ack", cpu_ack, 1);
        chk("rd_data", cpu_rdata, 32'hDEAD_BEEF);
        wait_idle(20);

        // dp write just past the end of memory
        do_reset();
        @(posedge clk);
        q_dp.push_back(mk(1, 32'h400, 32'h1234));
        @(negedge clk);
        chk("oor_no_we", dm_we, 0);
        @(negedge clk);
        chk("oor_ack", dp_ack, 1);
        chk("oor_err", dp_err, 1);
        wait_idle(20);

        // all three at once
        do_reset();
        gl.delete();
        @(posedge clk);
        q_cpu.push_back(mk(0, 32'h20, 0));
        q_conv.push_back(mk(0, 32'h24, 0));
        q_dp.push_back(mk(0, 32'h28, 0));
        wait_idle(40);
        chk("all3_n", gl.size(), 3);
        if (gl.size() == 3) begin
            chk("all3_g0", gl[0], 1);
            chk("all3_g1", gl[1], 2);
            chk("all3_g2", gl[2], 3);
        end

        // conv/dp round-robin, conv writes then dp reads the same words
        do_reset();
        gl.delete();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            q_conv.push_back(mk(1, 32'h40 + 32'(4 * i), 32'hC0DE_0000 + 32'(i)));
            q_dp.push_back(mk(0, 32'h40 + 32'(4 * i), 0));
        end
        wait_idle(60);
        chk("rr_n", gl.size(), 6);
        if (gl.size() == 6) begin
            chk("rr_g0", gl[0], 2);
            chk("rr_g1", gl[1], 3);
            chk("rr_g2", gl[2], 2);
            chk("rr_g3", gl[3], 3);
        end

        // CPU flood with conv waiting
        do_reset();
        gl.delete();
        @(posedge clk);
        for (int i = 0; i < 6; i++) q_cpu.push_back(mk(0, 32'(8 * i), 0));
        q_conv.push_back(mk(0, 32'h100, 0));
        q_conv.push_back(mk(0, 32'h104, 0));
        wait_idle(80);
        if (GUARD) exp_g = '{1, 1, 1, 1, 2, 1};
        else exp_g = '{1, 1, 1, 1, 1, 1};
        chk("starve_n", gl.size(), 8);
        if (gl.size() == 8)
            for (int i = 0; i < 6; i++) chk("starve_g", gl[i], exp_g[i]);

        // reset during RESP of a CPU write
        do_reset();
        cpu_acks = 0;
        @(posedge clk);
        q_cpu.push_back(mk(1, 32'h80, 32'hCAFE_F00D));
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("abort_ack", cpu_ack, 0);
        chk("abort_busy", busy, 0);
        chk("abort_grant", grant, 0);
        @(posedge clk);
        #3 rst = 0;
        wait_idle(20);
        chk("abort_acks", cpu_acks, 1);
        q_cpu.push_back(mk(0, 32'h80, 0));
        wait_idle(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
